// File: rtl/wb_char_render_pkg.sv
// Shared constants for the character renderer: register map, status bits,
// row-FSM state codes and glyph geometry.
package wb_char_render_pkg;

   localparam int GLYPH_ROWS = 8;
   localparam int GLYPH_COLS = 8;

   // Word offsets (wb_adr_i[3:2])
   localparam logic [1:0] REG_CHAR  = 2'd0;
   localparam logic [1:0] REG_POS   = 2'd1;
   localparam logic [1:0] REG_COLOR = 2'd2;
   localparam logic [1:0] REG_STAT  = 2'd3;

   // STAT read bits
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   // STAT write bits
   localparam int STAT_IRQ_EN = 0;
   localparam int STAT_CLR    = 1;

   // Row FSM states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/wb_char_render_if.sv
// Wishbone slave port plus the outgoing pixel stream of the character renderer.
// master = bus host / pixel sink side, slave = renderer side.
interface wb_char_render_if #(
   parameter int COL_W   = 6,
   parameter int ROW_W   = 5,
   parameter int COLOR_W = 16
);
   logic               wb_stb_i;
   logic               wb_cyc_i;
   logic               wb_we_i;
   logic [31:0]        wb_adr_i;
   logic [3:0]         wb_sel_i;
   logic [31:0]        wb_dat_i;
   logic               wb_ack_o;
   logic [31:0]        wb_dat_o;

   logic               pix_valid;
   logic               pix_ready;
   logic [COL_W+2:0]   pix_x;
   logic [ROW_W+2:0]   pix_y;
   logic [COLOR_W-1:0] pix_color;

   modport master (
      output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_ack_o, wb_dat_o,
      input  pix_valid, pix_x, pix_y, pix_color,
      output pix_ready
   );

   modport slave (
      input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_ack_o, wb_dat_o,
      output pix_valid, pix_x, pix_y, pix_color,
      input  pix_ready
   );
endinterface

// File: rtl/wb_char_render_serializer.sv
// Glyph-row serializer: holds one 8-bit font row and hands it out MSB first,
// one valid/ready beat per pixel. Valid follows the enable from the row FSM.
module char_row_serializer
   import wb_char_render_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] row_data,
   input  logic       en,
   input  logic       ready,
   output logic       valid,
   output logic       pix_bit,
   output logic [2:0] bit_idx,
   output logic       last
);

   logic [7:0] shreg;
   logic       fire;

   assign valid   = en;
   assign fire    = en & ready;
   assign pix_bit = shreg[7];
   assign last    = fire & (bit_idx == 3'(GLYPH_COLS - 1));

   // Load a fresh row, or advance one pixel on each accepted beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bit_idx <= '0;
      end else if (load) begin
         shreg   <= row_data;
         bit_idx <= '0;
      end else if (fire) begin
         shreg   <= {shreg[6:0], 1'b0};
         bit_idx <= bit_idx + 3'd1;
      end
   end

endmodule

// File: rtl/wb_char_render.sv
// Wishbone-configured character renderer: fetches 8 glyph rows from the font
// ROM and streams 64 coloured pixels to the LCD pixel writer.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | waiting for a CHAR write
//  FETCH    | rom_rd pulse for glyph row {code, glyph_row}
//  WAIT     | ROM data arrives, loaded into the serializer
//  SHIFT    | 8 pixel beats; after the last one go to next row or DONE
//  DONE     | set done, rewind glyph_row, back to IDLE
module wb_char_render
   import wb_char_render_pkg::*;
#(
   parameter int COL_W   = 6,
   parameter int ROW_W   = 5,
   parameter int COLOR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   wb_char_render_if.slave   bus,
   output logic              rom_rd,
   output logic [9:0]        rom_addr,
   input  logic [7:0]        rom_data,
   output logic              irq
);

   logic               ack_r;
   logic               wb_req;
   logic               wb_acc;
   logic               wr_acc;
   logic [1:0]         reg_sel;
   logic               wr_char;
   logic               wr_pos;
   logic               wr_color;
   logic               wr_stat;
   logic               busy;
   logic               cfg_drop;
   logic               stat_clr;
   logic [31:0]        rd_mux;

   logic [2:0]         state;
   logic [2:0]         glyph_row;
   logic [6:0]         code;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   cell_row;
   logic [COLOR_W-1:0] fg;
   logic [COLOR_W-1:0] bg;
   logic               irq_en;
   logic               done;
   logic               err;

   logic               ser_valid;
   logic               ser_bit;
   logic               ser_last;
   logic [2:0]         ser_idx;

   logic               unused_bits;

   // Only word offset [3:2] is decoded; byte selects are ignored
   assign unused_bits = ^{bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_adr_i[1:0]};

   // A request is accepted when no ack is outstanding; the ack cycle commits writes
   assign wb_req       = bus.wb_stb_i & bus.wb_cyc_i & ~ack_r;
   assign wb_acc       = bus.wb_stb_i & bus.wb_cyc_i & ack_r;
   assign bus.wb_ack_o = wb_acc;
   assign wr_acc       = wb_acc & bus.wb_we_i;
   assign reg_sel      = bus.wb_adr_i[3:2];

   assign wr_char  = wr_acc & (reg_sel == REG_CHAR);
   assign wr_pos   = wr_acc & (reg_sel == REG_POS);
   assign wr_color = wr_acc & (reg_sel == REG_COLOR);
   assign wr_stat  = wr_acc & (reg_sel == REG_STAT);

   // DONE still counts as busy, so a CHAR write landing there is refused
   assign busy     = (state != ST_IDLE);
   assign cfg_drop = busy & (wr_char | wr_pos | wr_color);
   assign stat_clr = wr_stat & bus.wb_dat_i[STAT_CLR];

   // Read data selection; CHAR reads as zero
   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_POS: begin
            rd_mux[COL_W-1:0]     = col;
            rd_mux[16+ROW_W-1:16] = cell_row;
         end
         REG_COLOR: begin
            rd_mux[COLOR_W-1:0]     = fg;
            rd_mux[16+COLOR_W-1:16] = bg;
         end
         REG_STAT: begin
            rd_mux[STAT_BUSY] = busy;
            rd_mux[STAT_DONE] = done;
            rd_mux[STAT_ERR]  = err;
         end
         default: rd_mux = '0;
      endcase
   end

   // Bus handshake: one-cycle ack with a bubble, read data registered with the request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_r        <= 1'b0;
         bus.wb_dat_o <= '0;
      end else begin
         ack_r <= wb_req;
         if (wb_req && !bus.wb_we_i) begin
            bus.wb_dat_o <= rd_mux;
         end
      end
   end

   // Register file; configuration is frozen while a render is in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         code     <= '0;
         col      <= '0;
         cell_row <= '0;
         fg       <= '0;
         bg       <= '0;
         irq_en   <= 1'b0;
         err      <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (wr_char && !busy) begin
            code <= bus.wb_dat_i[6:0];
         end
         if (wr_pos && !busy) begin
            col      <= bus.wb_dat_i[COL_W-1:0];
            cell_row <= bus.wb_dat_i[16+ROW_W-1:16];
         end
         if (wr_color && !busy) begin
            fg <= bus.wb_dat_i[COLOR_W-1:0];
            bg <= bus.wb_dat_i[16+COLOR_W-1:16];
         end
         if (wr_stat) begin
            irq_en <= bus.wb_dat_i[STAT_IRQ_EN];
         end
         if (cfg_drop) begin
            err <= 1'b1;
         end else if (stat_clr) begin
            err <= 1'b0;
         end
         // Completion beats a simultaneous clear
         if (state == ST_DONE) begin
            done <= 1'b1;
         end else if (stat_clr) begin
            done <= 1'b0;
         end
      end
   end

   // Row sequencer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         glyph_row <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_char) begin
                  state     <= ST_FETCH;
                  glyph_row <= '0;
               end
            end
            ST_FETCH: state <= ST_WAIT;
            ST_WAIT:  state <= ST_SHIFT;
            ST_SHIFT: begin
               if (ser_last) begin
                  glyph_row <= glyph_row + 3'd1;
                  state     <= (glyph_row == 3'(GLYPH_ROWS - 1)) ? ST_DONE : ST_FETCH;
               end
            end
            ST_DONE: begin
               glyph_row <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   char_row_serializer u_ser (
      .clk      (clk),
      .reset    (reset),
      .load     (state == ST_WAIT),
      .row_data (rom_data),
      .en       (state == ST_SHIFT),
      .ready    (bus.pix_ready),
      .valid    (ser_valid),
      .pix_bit  (ser_bit),
      .bit_idx  (ser_idx),
      .last     (ser_last)
   );

   assign rom_rd        = (state == ST_FETCH);
   assign rom_addr      = {code, glyph_row};
   assign bus.pix_valid = ser_valid;
   assign bus.pix_x     = {col, ser_idx};
   assign bus.pix_y     = {cell_row, glyph_row};
   assign bus.pix_color = ser_bit ? fg : bg;
   assign irq           = done & irq_en;

endmodule

// File: tb/tb_wb_char_render.sv
// Bench for wb_char_render: random font ROM, expected pixel/ROM-address lists
// built from the glyph arithmetic, monitor comparing every handshake.
module tb_wb_char_render;
   import wb_char_render_pkg::*;

   localparam int COL_W   = 6;
   localparam int ROW_W   = 5;
   localparam int COLOR_W = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rom_rd;
   logic [9:0] rom_addr;
   logic [7:0] rom_data = 8'h00;
   logic       irq;

   wb_char_render_if #(.COL_W(COL_W), .ROW_W(ROW_W), .COLOR_W(COLOR_W)) bus ();

   wb_char_render #(.COL_W(COL_W), .ROW_W(ROW_W), .COLOR_W(COLOR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .rom_rd   (rom_rd),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   logic [7:0] font [0:1023];
   always @(posedge clk) if (rom_rd) rom_data <= font[rom_addr];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Reference model state
   int          cur_col, cur_row;
   logic [15:0] cur_fg, cur_bg;
   logic [63:0] exp_pix[$];
   logic [9:0]  exp_rom[$];

   // Monitor state
   bit          mon_en = 0;
   bit          stalled = 0;
   logic [63:0] held;
   int          pix_cnt = 0, rom_cnt = 0;
   int          first_valid_cyc = -1, last_acc_cyc = 0;
   int          ack_cyc = 0, char_ack_cyc = 0;

   function automatic logic [63:0] pix_now();
      return {31'b0, bus.pix_x, bus.pix_y, bus.pix_color};
   endfunction

   always @(negedge clk) begin
      logic [63:0] ep;
      logic [9:0]  ea;
      if (mon_en) begin
         if (rom_rd) begin
            rom_cnt++;
            check("rom_rd_expected", {63'b0, exp_rom.size() != 0}, 64'd1);
            if (exp_rom.size() != 0) begin
               ea = exp_rom.pop_front();
               check("rom_addr", {54'b0, rom_addr}, {54'b0, ea});
            end
         end
         if (stalled) begin
            check("stall_valid", {63'b0, bus.pix_valid}, 64'd1);
            check("stall_hold", pix_now(), held);
         end
         stalled = 0;
         if (bus.pix_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
            if (bus.pix_ready) begin
               pix_cnt++;
               last_acc_cyc = cyc_cnt;
               check("pix_expected", {63'b0, exp_pix.size() != 0}, 64'd1);
               if (exp_pix.size() != 0) begin
                  ep = exp_pix.pop_front();
                  check("pix", pix_now(), ep);
               end
            end else begin
               stalled = 1;
               held = pix_now();
            end
         end
      end
   end

   task automatic wb_xfer(input logic we, input logic [1:0] sel, input logic [31:0] wdat,
                          output logic [31:0] rdat);
      int n = 0;
      @(posedge clk); #1;
      bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = we;
      bus.wb_adr_i = {28'h0, sel, 2'b00}; bus.wb_sel_i = 4'hF; bus.wb_dat_i = wdat;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.wb_ack_o && n < 8);
      if (!bus.wb_ack_o) check("wb_ack_timeout", {63'b0, bus.wb_ack_o}, 64'd1);
      ack_cyc = cyc_cnt;
      rdat = bus.wb_dat_o;
      @(posedge clk); #1;
      bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
   endtask

   task automatic wb_write(input logic [1:0] sel, input logic [31:0] d);
      logic [31:0] dummy;
      wb_xfer(1'b1, sel, d, dummy);
   endtask

   task automatic wb_read(input logic [1:0] sel, output logic [31:0] d);
      wb_xfer(1'b0, sel, 32'h0, d);
   endtask

   task automatic set_pos_raw(input logic [31:0] d);
      wb_write(REG_POS, d);
      cur_col = int'(d[5:0]);
      cur_row = int'(d[20:16]);
   endtask

   task automatic set_color(input logic [15:0] fg, input logic [15:0] bg);
      wb_write(REG_COLOR, {bg, fg});
      cur_fg = fg;
      cur_bg = bg;
   endtask

   task automatic plan_render(input logic [7:0] code_w);
      int          code;
      logic [9:0]  a;
      logic [7:0]  g;
      code = int'(code_w[6:0]);
      for (int r = 0; r < 8; r++) begin
         a = 10'(code * 8 + r);
         exp_rom.push_back(a);
         g = font[a];
         for (int b = 0; b < 8; b++)
            exp_pix.push_back({31'b0, 9'(cur_col * 8 + b), 8'(cur_row * 8 + r),
                               (g[7-b] ? cur_fg : cur_bg)});
      end
   endtask

   task automatic start_render(input logic [7:0] code_w);
      plan_render(code_w);
      pix_cnt = 0; rom_cnt = 0; first_valid_cyc = -1; stalled = 0;
      mon_en = 1;
      wb_write(REG_CHAR, {24'h0, code_w});
      char_ack_cyc = ack_cyc;
   endtask

   task automatic wait_render(input bit bp, input string tag);
      int n = 0;
      while (pix_cnt < 64 && n < 3000) begin
         @(posedge clk); #1;
         if (bp) bus.pix_ready = 1'($urandom_range(0, 1));
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_pix_cnt"}, 64'(pix_cnt), 64'd64);
      check({tag, "_pix_left"}, 64'(exp_pix.size()), 64'd0);
      check({tag, "_rom_left"}, 64'(exp_rom.size()), 64'd0);
      check({tag, "_rom_cnt"}, 64'(rom_cnt), 64'd8);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pix_valid"}, {63'b0, bus.pix_valid}, 64'd0);
      check({tag, "_pix_xyc"}, pix_now(), 64'd0);
      check({tag, "_rom_rd"}, {63'b0, rom_rd}, 64'd0);
      check({tag, "_rom_addr"}, {54'b0, rom_addr}, 64'd0);
      check({tag, "_irq"}, {63'b0, irq}, 64'd0);
      check({tag, "_ack"}, {63'b0, bus.wb_ack_o}, 64'd0);
      check({tag, "_dat_o"}, {32'b0, bus.wb_dat_o}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  c;
      logic [31:0] pr;
      logic [15:0] f, b;
      int          n;
      int          rc;

      bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
      bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
      bus.pix_ready = 0;
      for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
      font[10'h208] = 8'h18;
      cur_col = 0; cur_row = 0; cur_fg = '0; cur_bg = '0;

      // Power-on reset
      reset = 0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("por");
      @(negedge clk);
      reset = 1;
      wb_read(REG_STAT, d);
      check("por_stat", {32'b0, d}, 64'd0);

      // 'A' at cell (3,2), red on blue, ready held high
      set_pos_raw({16'd2, 16'd3});
      set_color(16'hF800, 16'h001F);
      wb_read(REG_POS, d);
      check("pos_rb", {32'b0, d}, {32'b0, 16'd2, 16'd3});
      bus.pix_ready = 1;
      start_render(8'h41);
      wait_render(0, "A");
      check("lat_first_valid", 64'(first_valid_cyc - char_ack_cyc), 64'd3);
      check("lat_total", 64'(last_acc_cyc - char_ack_cyc), 64'd80);
      wb_read(REG_STAT, d);
      check("A_stat", {32'b0, d}, 64'h2);
      wb_read(REG_CHAR, d);
      check("char_rd_zero", {32'b0, d}, 64'd0);
      wb_write(REG_STAT, 32'h2);
      wb_read(REG_STAT, d);
      check("A_stat_clr", {32'b0, d}, 64'd0);

      // Random cells and colours under random backpressure
      for (int it = 0; it < 3; it++) begin
         pr = $urandom;
         set_pos_raw(pr);
         wb_read(REG_POS, d);
         check("rnd_pos_rb", {32'b0, d}, {32'b0, 11'b0, pr[20:16], 10'b0, pr[5:0]});
         f = 16'($urandom); b = 16'($urandom);
         set_color(f, b);
         wb_read(REG_COLOR, d);
         check("rnd_color_rb", {32'b0, d}, {32'b0, b, f});
         c = 8'($urandom);
         start_render(c);
         wait_render(1, "rnd");
         wb_read(REG_STAT, d);
         check("rnd_stat", {32'b0, d}, 64'h2);
         wb_write(REG_STAT, 32'h2);
      end

      // Writes while busy are dropped and flag err
      set_pos_raw({16'd7, 16'd11});
      set_color(16'h1234, 16'hABCD);
      bus.pix_ready = 0;
      start_render(8'($urandom));
      n = 0;
      while (!bus.pix_valid && n < 20) begin @(negedge clk); n++; end
      check("busy_valid_seen", {63'b0, bus.pix_valid}, 64'd1);
      wb_write(REG_COLOR, 32'h5555_AAAA);
      wb_write(REG_POS, 32'h0001_0001);
      wb_write(REG_CHAR, 32'h0000_0022);
      wb_read(REG_COLOR, d);
      check("busy_color_kept", {32'b0, d}, {32'b0, 16'hABCD, 16'h1234});
      wb_read(REG_POS, d);
      check("busy_pos_kept", {32'b0, d}, {32'b0, 16'd7, 16'd11});
      wb_read(REG_STAT, d);
      check("busy_stat_err", {32'b0, d}, 64'h5);
      wb_write(REG_STAT, 32'h2);
      wb_read(REG_STAT, d);
      check("busy_stat_clr", {32'b0, d}, 64'h1);
      bus.pix_ready = 1;
      wait_render(0, "busy");
      wb_write(REG_STAT, 32'h2);

      // irq follows done when enabled; back-to-back STAT reads
      wb_write(REG_STAT, 32'h3);
      set_pos_raw($urandom);
      set_color(16'($urandom), 16'($urandom));
      start_render(8'h7F);
      #1;
      check("irq_low_running", {63'b0, irq}, 64'd0);
      wait_render(0, "irq");
      check("irq_high", {63'b0, irq}, 64'd1);

      @(posedge clk); #1;
      bus.wb_stb_i = 1; bus.wb_cyc_i = 1; bus.wb_we_i = 0;
      bus.wb_adr_i = {28'h0, REG_STAT, 2'b00};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b2b_ack", {63'b0, bus.wb_ack_o}, 64'(i % 2));
         if (bus.wb_ack_o) check("b2b_dat", {32'b0, bus.wb_dat_o}, 64'h2);
      end
      @(posedge clk); #1;
      bus.wb_stb_i = 0; bus.wb_cyc_i = 0;

      wb_write(REG_STAT, 32'h2);
      #1;
      check("irq_cleared", {63'b0, irq}, 64'd0);

      // CHAR write acked in the DONE cycle is refused
      bus.pix_ready = 1;
      start_render(8'($urandom));
      repeat (78) @(posedge clk);
      wb_write(REG_CHAR, 32'h0000_0055);
      repeat (12) @(posedge clk);
      wait_render(0, "done_char");
      wb_read(REG_STAT, d);
      check("done_char_stat", {32'b0, d}, 64'h6);
      wb_write(REG_STAT, 32'h2);

      // Clear acked in the DONE cycle loses to the done set
      start_render(8'($urandom));
      repeat (78) @(posedge clk);
      wb_write(REG_STAT, 32'h2);
      wait_render(0, "done_clr");
      wb_read(REG_STAT, d);
      check("done_clr_stat", {32'b0, d}, 64'h2);
      wb_write(REG_STAT, 32'h3);

      // Asynchronous reset in the middle of a render
      set_pos_raw({16'd9, 16'd5});
      set_color(16'hFFFF, 16'h7777);
      wb_read(REG_STAT, d);
      bus.pix_ready = 0;
      start_render(8'($urandom));
      n = 0;
      while (!bus.pix_valid && n < 20) begin @(negedge clk); n++; end
      check("mid_valid_seen", {63'b0, bus.pix_valid}, 64'd1);
      mon_en = 0;
      #2;
      reset = 0;
      #1;
      check_outputs_zero("mid_rst");
      exp_pix.delete();
      exp_rom.delete();
      stalled = 0;
      rc = rom_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1;
      bus.pix_ready = 1;
      mon_en = 1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_rom_cnt", 64'(rom_cnt), 64'(rc));
      mon_en = 0;
      wb_read(REG_STAT, d);
      check("post_rst_stat", {32'b0, d}, 64'd0);
      wb_read(REG_POS, d);
      check("post_rst_pos", {32'b0, d}, 64'd0);
      check("post_rst_irq", {63'b0, irq}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
